// File: rtl/byte_to_word_packer_pkg.sv
// Shared constants, packer state type and lane-mask helper for the byte-to-word packer.
package pack_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * LANE_W;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Keep mask for a word holding cnt bytes; little-endian fills from lane 0, big-endian from lane 3.
  function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [2:0] cnt, input logic le);
    logic [BYTES_PER_WORD-1:0] m;
    case (cnt)
      3'd0:    m = 4'b0000;
      3'd1:    m = le ? 4'b0001 : 4'b1000;
      3'd2:    m = le ? 4'b0011 : 4'b1100;
      3'd3:    m = le ? 4'b0111 : 4'b1110;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/word_out_reg.sv
// Single-entry valid/ready register slice for a word with keep and last sidebands.
module word_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready
);

  // The slot is free when empty or when the current word leaves this cycle.
  assign in_ready = !m_valid || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      m_valid <= 1'b1;
      m_data  <= in_data;
      m_keep  <= in_keep;
      m_last  <= in_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_to_word_packer.sv
// Packs a valid/ready byte stream into 32-bit words with partial-word support via s_last
// and an optional idle-timeout flush; a completed word waits in the accumulator under back-pressure.
module byte_to_word_packer
  import pack_pkg::*;
#(
  parameter bit BYTE_LE        = 1'b1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_W           = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANE_W-1:0]         s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      s_last,
  output logic [WORD_W-1:0]         m_data,
  output logic [BYTES_PER_WORD-1:0] m_keep,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready
);

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  pack_state_e               state_q, state_d;
  logic [1:0]                byte_cnt;
  logic [WORD_W-1:0]         acc_data;
  logic [BYTES_PER_WORD-1:0] acc_keep;
  logic                      acc_last;
  logic [TO_W-1:0]           idle_cnt;

  logic                      acc_full, accept, timeout_fire, complete, out_free;
  logic [1:0]                lane;
  logic [WORD_W-1:0]         word_data, ld_data;
  logic [BYTES_PER_WORD-1:0] word_keep, ld_keep;
  logic                      word_last, ld_last, ld_valid;

  assign acc_full = (state_q == HOLD);
  assign s_ready  = !acc_full;
  assign accept   = s_valid && s_ready;
  assign lane     = BYTE_LE ? byte_cnt : (2'd3 - byte_cnt);

  // An empty accumulator never times out, so no zero-keep word can be produced.
  assign timeout_fire = TO_EN && !acc_full && (byte_cnt != 2'd0) && !accept && (idle_cnt == TO_LAST);
  assign complete     = (accept && ((byte_cnt == 2'd3) || s_last)) || timeout_fire;

  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    word_last = 1'b0;
    if (accept) begin
      word_data[lane*LANE_W +: LANE_W] = s_data;
      word_keep = keep_mask({1'b0, byte_cnt} + 3'd1, BYTE_LE);
      word_last = s_last;
    end
  end

  // A held word has priority; otherwise the freshly completed word goes straight out.
  assign ld_valid = acc_full || complete;
  assign ld_data  = acc_full ? acc_data : word_data;
  assign ld_keep  = acc_full ? acc_keep : word_keep;
  assign ld_last  = acc_full ? acc_last : word_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (complete && !out_free) state_d = HOLD;
      HOLD:    if (out_free)              state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (complete) begin
        byte_cnt <= 2'd0;
        if (out_free) begin
          acc_data <= '0;
          acc_keep <= '0;
          acc_last <= 1'b0;
        end else begin
          acc_data <= word_data;
          acc_keep <= word_keep;
          acc_last <= word_last;
        end
      end else if (acc_full && out_free) begin
        acc_data <= '0;
        acc_keep <= '0;
        acc_last <= 1'b0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        acc_data <= word_data;
        acc_keep <= word_keep;
      end

      if (accept || complete || acc_full || (byte_cnt == 2'd0) || !TO_EN) idle_cnt <= '0;
      else                                                                idle_cnt <= idle_cnt + 1'b1;
    end
  end

  word_out_reg #(
    .DATA_W(WORD_W),
    .KEEP_W(BYTES_PER_WORD)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(ld_valid),
    .in_data (ld_data),
    .in_keep (ld_keep),
    .in_last (ld_last),
    .in_ready(out_free),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

endmodule

// File: tb/tb_byte_to_word_packer.sv
// Scoreboard bench: a little-endian packer with idle timeout and a big-endian packer without one.
module tb_byte_to_word_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data, s_data_be;
  logic        s_valid, s_valid_be, s_last, s_last_be;
  logic        s_ready, s_ready_be;
  logic [31:0] m_data, m_data_be;
  logic [3:0]  m_keep, m_keep_be;
  logic        m_last, m_last_be, m_valid, m_valid_be;
  logic        m_ready, m_ready_be;

  exp_t q_le[$];
  exp_t q_be[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  byte_to_word_packer #(.BYTE_LE(1'b1), .TIMEOUT_CYCLES(8), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  byte_to_word_packer #(.BYTE_LE(1'b0), .TIMEOUT_CYCLES(0), .TO_W(16)) dut_be (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_be), .s_valid(s_valid_be), .s_ready(s_ready_be),
    .s_last(s_last_be), .m_data(m_data_be), .m_keep(m_keep_be), .m_last(m_last_be),
    .m_valid(m_valid_be), .m_ready(m_ready_be)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitors: a word is consumed whenever valid and ready meet at the sampling point.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (q_le.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL le_unexpected: got %h/%b/%b, expected no word", m_data, m_keep, m_last);
      end else begin
        exp_t e;
        e = q_le.pop_front();
        chk("le_word", {27'd0, m_data, m_keep, m_last}, {27'd0, e.d, e.k, e.l});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid_be && m_ready_be) begin
      if (q_be.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL be_unexpected: got %h/%b/%b, expected no word", m_data_be, m_keep_be, m_last_be);
      end else begin
        exp_t e;
        e = q_be.pop_front();
        chk("be_word", {27'd0, m_data_be, m_keep_be, m_last_be}, {27'd0, e.d, e.k, e.l});
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic send(input bit be, input logic [7:0] d, input bit l);
    int t = 0;
    if (be) begin s_data_be = d; s_last_be = l; s_valid_be = 1'b1; end
    else    begin s_data    = d; s_last    = l; s_valid    = 1'b1; end
    while (!(be ? s_ready_be : s_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got s_ready=0 for %0d cycles, expected acceptance", t);
    end
    @(negedge clk);
    if (be) begin s_valid_be = 1'b0; s_last_be = 1'b0; end
    else    begin s_valid    = 1'b0; s_last    = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    s_data_be = '0; s_valid_be = 1'b0; s_last_be = 1'b0;
    m_ready = 1'b1; m_ready_be = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_m_out", {27'd0, m_data, m_keep, m_last}, 64'd0);
    chk("rst_be_out", {26'd0, m_valid_be, m_data_be, m_keep_be, m_last_be}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full little-endian word, one cycle latency after the 4th byte
    q_le.push_back('{32'h4433_2211, 4'b1111, 1'b0});
    send(1'b0, 8'h11, 1'b0); send(1'b0, 8'h22, 1'b0); send(1'b0, 8'h33, 1'b0);
    chk("t1_no_early", {63'd0, m_valid}, 64'd0);
    send(1'b0, 8'h44, 1'b0);
    chk("t1_latency", {63'd0, m_valid}, 64'd1);

    // Big-endian full and partial words
    q_be.push_back('{32'h1122_3344, 4'b1111, 1'b0});
    q_be.push_back('{32'hAABB_0000, 4'b1100, 1'b1});
    send(1'b1, 8'h11, 1'b0); send(1'b1, 8'h22, 1'b0); send(1'b1, 8'h33, 1'b0); send(1'b1, 8'h44, 1'b0);
    send(1'b1, 8'hAA, 1'b0); send(1'b1, 8'hBB, 1'b1);

    // Partial words closed by s_last, including s_last on the 4th byte
    q_le.push_back('{32'h0000_BBAA, 4'b0011, 1'b1});
    q_le.push_back('{32'h0000_0055, 4'b0001, 1'b1});
    q_le.push_back('{32'h0063_6261, 4'b0111, 1'b1});
    q_le.push_back('{32'h7473_7271, 4'b1111, 1'b1});
    send(1'b0, 8'hAA, 1'b0); send(1'b0, 8'hBB, 1'b1);
    chk("t3_last_latency", {63'd0, m_valid}, 64'd1);
    send(1'b0, 8'h55, 1'b1);
    send(1'b0, 8'h61, 1'b0); send(1'b0, 8'h62, 1'b0); send(1'b0, 8'h63, 1'b1);
    send(1'b0, 8'h71, 1'b0); send(1'b0, 8'h72, 1'b0); send(1'b0, 8'h73, 1'b0); send(1'b0, 8'h74, 1'b1);

    // Back-pressure: one word at the output, one held in the accumulator
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    q_le.push_back('{32'h0403_0201, 4'b1111, 1'b0});
    q_le.push_back('{32'h0807_0605, 4'b1111, 1'b0});
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(i), 1'b0);
    chk("t4_s_ready_held", {63'd0, s_ready}, 64'd0);
    chk("t4_m_valid", {63'd0, m_valid}, 64'd1);
    repeat (3) @(negedge clk);
    chk("t4_stable", {27'd0, m_data, m_keep, m_last}, {27'd0, 32'h0403_0201, 4'b1111, 1'b0});
    chk("t4_still_blocked", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1 m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_drained", {63'd0, m_valid}, 64'd0);
    q_le.push_back('{32'h0C0B_0A09, 4'b1111, 1'b0});
    send(1'b0, 8'h09, 1'b0); send(1'b0, 8'h0A, 1'b0); send(1'b0, 8'h0B, 1'b0); send(1'b0, 8'h0C, 1'b0);
    @(negedge clk);

    // Idle-timeout flush after 8 idle cycles
    q_le.push_back('{32'h0003_0201, 4'b0111, 1'b0});
    send(1'b0, 8'h01, 1'b0); send(1'b0, 8'h02, 1'b0); send(1'b0, 8'h03, 1'b0);
    repeat (7) @(negedge clk);
    chk("t5_before_timeout", {63'd0, m_valid}, 64'd0);
    @(negedge clk);
    chk("t5_timeout_flush", {63'd0, m_valid}, 64'd1);
    @(negedge clk);

    // Reset mid-word drops the partial word
    send(1'b0, 8'hDE, 1'b0); send(1'b0, 8'hAD, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("t6_rst_s_ready", {63'd0, s_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_no_output", {63'd0, m_valid}, 64'd0);
    q_le.push_back('{32'hA4A3_A2A1, 4'b1111, 1'b0});
    send(1'b0, 8'hA1, 1'b0); send(1'b0, 8'hA2, 1'b0); send(1'b0, 8'hA3, 1'b0); send(1'b0, 8'hA4, 1'b0);

    repeat (4) @(negedge clk);
    chk("le_queue_empty", 64'(q_le.size()), 64'd0);
    chk("be_queue_empty", 64'(q_be.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
